hazard_sched: RTL
=================

Name: hazard_sched

Overview:
- Pipeline interlock scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- EX has no operand forwarding, so this block tracks the destination registers of in-flight writers in a scoreboard.
- It stalls IF/ID and injects EX bubbles on read-after-write hazards, flushes on taken branches, and sequences a drain-and-halt for debug/test.

Parameters:
- DEPTH, 3, scoreboard entries tracked (EX, MEM, WB in-flight writers).
- WB_BYPASS, 1, 1 = the register file writes in the first half-cycle, so the oldest entry (WB) never causes a hazard.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_rwd  in  5  ID destination register.
- id_wr  in  1  instruction writes id_rwd.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- halt_req  in  1  request pipeline drain and halt (level).
- resume  in  1  leave HALTED (pulse).
- stall  out  1  hold PC and IF/ID registers.
- bubble  out  1  load a NOP (opcode 0, rwd 0) into ID/EX instead of ID contents.
- flush  out  1  squash IF/ID contents.
- halted  out  1  pipeline empty and frozen.
- stall_cnt  out  CNT_W  cycles lost to hazard stalls.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Scoreboard: DEPTH entries {v, rd}. Every cycle, entry[i+1] <= entry[i].
- entry[0] <= {1, id_rwd} on issue. Issue = RUN & id_valid & id_wr & id_rwd!=0 & ~stall & ~flush. Otherwise entry[0] <= {0, x}.
- Hazard: id_valid & ((id_use_rs & id_rs!=0 & match(id_rs)) | (id_use_rt & id_rt!=0 & match(id_rt))).
  - match(r) = any valid entry[i].rd==r, for i in 0..DEPTH-1-WB_BYPASS.
  - Register 0 never hazards.
- Outputs are combinational from the registered scoreboard/state and the current ID inputs; no added latency.
- FSM states: RUN, DRAIN, HALTED.
- RUN:
  - flush = branch_taken.
  - stall = hazard & ~branch_taken.
  - bubble = hazard | branch_taken.
  - halt_req=1 -> DRAIN next cycle (evaluated after the current cycle's outputs).
- DRAIN:
  - stall=1 and bubble=1; flush = branch_taken.
  - No issue; the scoreboard shifts empty.
  - When all DEPTH entries are invalid -> HALTED.
- HALTED:
  - stall=1, bubble=1, flush=0, halted=1.
  - resume=1 -> RUN next cycle.
  - halt_req is ignored in HALTED.
  - resume is ignored in RUN and DRAIN.
- Simultaneous branch_taken & hazard: flush wins. The ID instruction is squashed, stall=0, bubble=1, nothing enters the scoreboard.
- halt_req dropped during DRAIN: the drain still completes to HALTED.
- Latency: a load/ALU writer in EX blocks a dependent ID instruction for 2 cycles with WB_BYPASS=1 (3 with WB_BYPASS=0). The dependent instruction issues in the cycle the writer reaches WB (respectively leaves WB).
- Counters:
  - stall_cnt += 1 on each RUN cycle with stall=1.
  - flush_cnt += 1 on each flush=1 cycle.
  - Both saturate at all-ones and do not wrap.
- Reset (sync, rst high at posedge):
  - Scoreboard cleared, state=RUN, counters=0.
  - While rst is high: stall=0, flush=0, bubble=1, halted=0.
  - Reset mid-DRAIN or mid-HALTED returns to RUN with an empty scoreboard.

Test Plan:
- Independent stream (writer r1, then reader r2/r3) -> stall=0 every cycle, bubble=0, stall_cnt stays 0.
- Writer r5 issues, then reader rs=5 next cycle, WB_BYPASS=1 -> stall=1 for 2 cycles, bubble=1 for those 2 cycles; reader issues on the 3rd cycle; stall_cnt=2.
- Writer to r0, then reader rs=0 -> no stall; scoreboard entry[0].v=0.
- Hazard cycle with branch_taken=1 -> flush=1, stall=0, bubble=1; flush_cnt=1; the squashed rwd never matches later.
- halt_req with 2 writers in flight -> DRAIN, then HALTED with halted=1 after the scoreboard empties (≤3 cycles). resume -> RUN next cycle, stall=0.
- rst asserted mid-DRAIN; force stall_cnt to all-ones then stall again -> state RUN, counters 0 after reset; saturated counter stays 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_sched_if.sv
// ID-stage, branch and debug request inputs plus the interlock and counter outputs of hazard_sched.
// The CNT_W parameter of this interface must match the CNT_W of the scheduler it is connected to.
interface hazard_sched_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_rwd;
    logic             id_wr;
    logic             branch_taken;
    logic             halt_req;
    logic             resume;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rwd, id_wr,
               branch_taken, halt_req, resume,
        input  stall, bubble, flush, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rwd, id_wr,
               branch_taken, halt_req, resume,
        output stall, bubble, flush, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sched.sv
// Interlock scheduler for a 5-stage pipeline without EX forwarding: RAW stalls, branch flushes,
// and a drain-then-halt sequence for debug, driven from a shift-register scoreboard of in-flight writers.
module hazard_sched #(
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    hazard_sched_if.slave  hs
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // With the write-first register file, the WB entry is already visible to ID reads.
    localparam int CHK = DEPTH - WB_BYPASS;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [DEPTH-1:0]        sb_v_r;
    logic [DEPTH-1:0][4:0]   sb_rd_r;
    logic [CNT_W-1:0]        stall_cnt_r;
    logic [CNT_W-1:0]        flush_cnt_r;
    logic                    hazard_s;
    logic                    issue_s;
    logic                    stall_s;
    logic                    bubble_s;
    logic                    flush_s;
    logic                    halted_s;

    function automatic logic sb_match(
        input logic [4:0]            r,
        input logic [DEPTH-1:0]      v,
        input logic [DEPTH-1:0][4:0] rd
    );
        logic m;
        m = 1'b0;
        for (int i = 0; i < CHK; i++) begin
            m = m | (v[i] & (rd[i] == r));
        end
        return m;
    endfunction

    assign hazard_s = hs.id_valid &
                      ((hs.id_use_rs & (hs.id_rs != 5'd0) & sb_match(hs.id_rs, sb_v_r, sb_rd_r)) |
                       (hs.id_use_rt & (hs.id_rt != 5'd0) & sb_match(hs.id_rt, sb_v_r, sb_rd_r)));

    assign issue_s = (state_r == ST_RUN) & hs.id_valid & hs.id_wr & (hs.id_rwd != 5'd0) &
                     ~stall_s & ~flush_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: halt request drains, an empty scoreboard halts, resume restarts
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN:    state_nx_s = hs.halt_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN:  state_nx_s = (sb_v_r == {DEPTH{1'b0}}) ? ST_HALTED : ST_DRAIN;
            ST_HALTED: state_nx_s = hs.resume ? ST_RUN : ST_HALTED;
            default:   state_nx_s = ST_RUN;
        endcase
    end

    // Output logic; an illegal state freezes the pipeline until the next-state logic recovers it
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b1;
        flush_s  = 1'b0;
        halted_s = 1'b0;
        if (rst) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    flush_s  = hs.branch_taken;
                    stall_s  = hazard_s & ~hs.branch_taken;
                    bubble_s = hazard_s | hs.branch_taken;
                end
                ST_DRAIN: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    flush_s  = hs.branch_taken;
                end
                ST_HALTED: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    halted_s = 1'b1;
                end
                default: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                end
            endcase
        end
    end

    // Scoreboard shift: entry 0 takes the issuing writer, older entries age toward WB
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v_r  <= {DEPTH{1'b0}};
            sb_rd_r <= {(DEPTH*5){1'b0}};
        end else begin
            sb_v_r  <= {sb_v_r[DEPTH-2:0], issue_s};
            sb_rd_r <= {sb_rd_r[DEPTH-2:0], (issue_s ? hs.id_rwd : 5'd0)};
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == ST_RUN) && stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign hs.stall     = stall_s;
    assign hs.bubble    = bubble_s;
    assign hs.flush     = flush_s;
    assign hs.halted    = halted_s;
    assign hs.stall_cnt = stall_cnt_r;
    assign hs.flush_cnt = flush_cnt_r;
endmodule
